// File: rtl/mult_div_unit_pkg.sv
// Shared op encodings, latencies and result type for the E-stage multiply/divide unit.
package mult_div_unit_pkg;

  localparam logic [3:0] MDNONEop = 4'd0;
  localparam logic [3:0] MULTop   = 4'd1;
  localparam logic [3:0] MULTUop  = 4'd2;
  localparam logic [3:0] DIVop    = 4'd3;
  localparam logic [3:0] DIVUop   = 4'd4;
  localparam logic [3:0] MFHIop   = 4'd5;
  localparam logic [3:0] MFLOop   = 4'd6;
  localparam logic [3:0] MTHIop   = 4'd7;
  localparam logic [3:0] MTLOop   = 4'd8;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } md_res_t;

  function automatic logic is_md_op(input logic [3:0] op);
    return (op == MULTop) || (op == MULTUop) || (op == DIVop) || (op == DIVUop);
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// E-stage bus between the pipeline and the multiply/divide unit.
interface mult_div_unit_if;
  logic [3:0]  MDop;
  logic [31:0] A;
  logic [31:0] B;
  logic        start;
  logic        busy;
  logic [31:0] MDout;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (output MDop, A, B, input start, busy, MDout, HI, LO);
  modport slave  (input MDop, A, B, output start, busy, MDout, HI, LO);
endinterface

// File: rtl/mult_div_unit_md_timer.sv
// Busy timer: load N-1, count down each edge, done while the count sits at 0 in RUN.
module md_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] n,
  output logic             busy,
  output logic             done
);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;

  assign busy = (state == S_RUN);
  assign done = busy && (cnt == '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else if (state == S_IDLE) begin
      if (load) begin
        state <= S_RUN;
        cnt   <= n;
      end
    end else if (cnt == '0) begin
      state <= S_IDLE;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end
endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle MULT/DIV beside the ALU: result computed at start, held in shadow regs,
// committed to HI/LO on the edge busy falls.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input logic         clk,
  input logic         reset,
  mult_div_unit_if.slave md
);
  localparam int MAXC  = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W = $clog2(MAXC) + 1;

  logic [31:0] hi_r, lo_r, hi_s, lo_s;
  logic        busy, done, start;
  logic [CNT_W-1:0] n_load;

  logic [63:0] prod_s, prod_u;
  logic [31:0] a_abs, b_abs, dvd, dvs, qu, ru, q_s, r_s;
  logic        is_mul, is_sdiv, div_zero;
  md_res_t     res;

  assign start   = is_md_op(md.MDop) && !busy;
  assign is_mul  = (md.MDop == MULTop) || (md.MDop == MULTUop);
  assign is_sdiv = (md.MDop == DIVop);
  assign n_load  = is_mul ? CNT_W'(MULT_CYCLES - 1) : CNT_W'(DIV_CYCLES - 1);

  // Low 64 bits of the sign-extended product equal the signed 64-bit product.
  assign prod_s = {{32{md.A[31]}}, md.A} * {{32{md.B[31]}}, md.B};
  assign prod_u = {32'b0, md.A} * {32'b0, md.B};

  // One unsigned divider shared by DIV and DIVU; signed results are fixed up from magnitudes.
  assign a_abs    = md.A[31] ? (~md.A + 32'd1) : md.A;
  assign b_abs    = md.B[31] ? (~md.B + 32'd1) : md.B;
  assign div_zero = (md.B == 32'd0);
  assign dvd      = is_sdiv ? a_abs : md.A;
  assign dvs      = div_zero ? 32'd1 : (is_sdiv ? b_abs : md.B);
  assign qu       = dvd / dvs;
  assign ru       = dvd % dvs;
  assign q_s      = (md.A[31] ^ md.B[31]) ? (~qu + 32'd1) : qu;
  assign r_s      = md.A[31] ? (~ru + 32'd1) : ru;

  always_comb begin
    res = '{hi: hi_r, lo: lo_r};
    case (md.MDop)
      MULTop:  res = prod_s;
      MULTUop: res = prod_u;
      DIVop:   if (!div_zero) res = '{hi: r_s, lo: q_s};
      DIVUop:  if (!div_zero) res = '{hi: ru,  lo: qu};
      default: res = '{hi: hi_r, lo: lo_r};
    endcase
  end

  md_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (start),
    .n     (n_load),
    .busy  (busy),
    .done  (done)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      hi_r <= '0;
      lo_r <= '0;
      hi_s <= '0;
      lo_s <= '0;
    end else if (done) begin
      hi_r <= hi_s;
      lo_r <= lo_s;
    end else if (start) begin
      hi_s <= res.hi;
      lo_s <= res.lo;
    end else if (!busy) begin
      if (md.MDop == MTHIop) hi_r <= md.A;
      if (md.MDop == MTLOop) lo_r <= md.A;
    end
  end

  assign md.start = start;
  assign md.busy  = busy;
  assign md.HI    = hi_r;
  assign md.LO    = lo_r;
  assign md.MDout = (md.MDop == MFHIop) ? hi_r :
                    (md.MDop == MFLOop) ? lo_r : 32'd0;
endmodule
